// File: rtl/ss_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment bit positions,
// hex glyph ROM (active-high a..g) and the all-off output pattern.
package ss_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] ss_dark = 8'hFF;

    // Bit order {g,f,e,d,c,b,a}; 0xA-0xF render as A, b, C, d, E, F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Pack active-high segments plus DP into the active-low pin pattern.
    function automatic logic [7:0] seg_drive(input logic [6:0] segs, input logic dp);
        logic [7:0] on;
        on              = 8'h00;
        on[SEG_G:SEG_A] = segs;
        on[SEG_DP]      = dp;
        return ~on;
    endfunction

endpackage

// File: rtl/ss_glyph_decoder.sv
// Hex code to active-high a..g segment pattern; purely combinational, no state.
module ss_glyph_decoder
    import ss_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] segments
);

    assign segments = GLYPHS[code];

endmodule

// File: rtl/ss_mux_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with PWM dimming,
// anti-ghost blank interval and leading-zero suppression; all outputs registered.
module ss_mux_driver
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 200_000,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [4*NUM_DIGITS-1:0] Bcd,
    input  logic [NUM_DIGITS-1:0]   Dp,
    input  logic [PWM_BITS-1:0]     Duty,
    input  logic                    BlankLeading,
    output logic [NUM_DIGITS-1:0]   SegmentDrivers,
    output logic [7:0]              SevenSegment,
    output logic                    FrameStart
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);

    if (DIV <= BLANK_CYCLES) begin : g_div_check
        $error("ss_mux_driver: CLK_HZ/SCAN_HZ must exceed BLANK_CYCLES");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_digit_check
        $error("ss_mux_driver: NUM_DIGITS must be 1..16");
    end

    logic [PW-1:0]           p;
    logic [DW-1:0]           d;
    logic [PWM_BITS-1:0]     w;

    logic [4*NUM_DIGITS-1:0] bcd_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic [PWM_BITS-1:0]     duty_s;
    logic                    blank_leading_s;

    logic tick;
    logic frame_wrap;
    logic in_window;

    assign tick       = (p == P_LAST);
    assign frame_wrap = tick && (d == D_LAST);
    assign in_window  = (p >= P_BLANK);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            p <= '0;
            d <= '0;
            w <= '0;
        end else if (tick) begin
            p <= '0;
            w <= '0;
            d <= frame_wrap ? '0 : d + 1'b1;
        end else begin
            p <= p + 1'b1;
            if (in_window) begin
                w <= w + 1'b1;
            end
        end
    end

    // Inputs are sampled only at frame wrap so a multi-digit value never tears.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bcd_s           <= '0;
            dp_s            <= '0;
            duty_s          <= '0;
            blank_leading_s <= 1'b0;
        end else if (frame_wrap) begin
            bcd_s           <= Bcd;
            dp_s            <= Dp;
            duty_s          <= Duty;
            blank_leading_s <= BlankLeading;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= frame_wrap;
        end
    end

    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  upper_zero;

    // Walk down from the most significant digit; blanking stops at the first non-zero nibble.
    always_comb begin
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero && (bcd_s[4*k +: 4] == 4'h0);
            blank_mask[k] = blank_leading_s && upper_zero;
        end
    end

    logic [3:0] nibble;
    logic       digit_dp;
    logic       digit_blanked;

    always_comb begin
        nibble        = 4'h0;
        digit_dp      = 1'b0;
        digit_blanked = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (d == DW'(k)) begin
                nibble        = bcd_s[4*k +: 4];
                digit_dp      = dp_s[k];
                digit_blanked = blank_mask[k];
            end
        end
    end

    logic [6:0] glyph;

    ss_glyph_decoder u_glyph (
        .code     (nibble),
        .segments (glyph)
    );

    logic pwm_on;
    logic lit;

    assign pwm_on = (&duty_s) || (w < duty_s);
    assign lit    = Enable && in_window && pwm_on && (!digit_blanked || digit_dp);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            SegmentDrivers <= '1;
            SevenSegment   <= ss_dark;
        end else if (lit) begin
            SegmentDrivers <= ~(NUM_DIGITS'(1) << d);
            SevenSegment   <= seg_drive(digit_blanked ? 7'h00 : glyph, digit_dp);
        end else begin
            SegmentDrivers <= '1;
            SevenSegment   <= ss_dark;
        end
    end

endmodule

// File: tb/tb_ss_mux_driver.sv
// Bench for ss_mux_driver: cycle scoreboard from a frame-time model, table of display
// patterns, and hand sequences for reset, tearing and enable.
module tb_ss_mux_driver;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;
    localparam int NV    = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [15:0] Bcd = 16'h0;
    logic [3:0]  Dp = 4'h0;
    logic [1:0]  Duty = 2'b00;
    logic        BlankLeading = 1'b0;
    logic [3:0]  SegmentDrivers;
    logic [7:0]  SevenSegment;
    logic        FrameStart;

    ss_mux_driver #(
        .NUM_DIGITS   (N),
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .PWM_BITS     (2),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Enable         (Enable),
        .Bcd            (Bcd),
        .Dp             (Dp),
        .Duty           (Duty),
        .BlankLeading   (BlankLeading),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment),
        .FrameStart     (FrameStart)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0] drv;
        logic [7:0] seg;
        logic       fs;
    } obs_t;

    obs_t exp_q [$];

    // Reference model: scan position derived from cycles elapsed since reset release.
    int          t;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    logic [1:0]  m_duty;
    logic        m_bl;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            t      = 0;
            m_bcd  = '0;
            m_dp   = '0;
            m_duty = '0;
            m_bl   = 1'b0;
            exp_q.delete();
        end else begin : model
            int   mp, md, mw;
            logic blanked, pwm, lit;
            logic [3:0] nib;
            obs_t e;
            mp      = t % DIV;
            md      = (t / DIV) % N;
            mw      = (mp < BLANK) ? 0 : (mp - BLANK) % 4;
            nib     = 4'(m_bcd >> (4 * md));
            blanked = m_bl && (md != 0) && ((m_bcd >> (4 * md)) == 16'h0);
            pwm     = (m_duty == 2'b11) || (mw < int'(m_duty));
            lit     = Enable && (mp >= BLANK) && pwm && (!blanked || m_dp[md]);
            e.drv   = lit ? ~(4'b0001 << md) : 4'hF;
            e.seg   = lit ? ~{m_dp[md], (blanked ? 7'h00 : ref_glyph(nib))} : 8'hFF;
            t       = t + 1;
            e.fs    = (t % FRAME == 0);
            if (t % FRAME == 0) begin
                m_bcd  = Bcd;
                m_dp   = Dp;
                m_duty = Duty;
                m_bl   = BlankLeading;
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge Clk) begin
        if (!Reset && exp_q.size() > 0) begin : compare
            obs_t e;
            e = exp_q.pop_front();
            check("sb_drivers", SegmentDrivers, e.drv);
            check("sb_segments", SevenSegment, e.seg);
            check("sb_framestart", FrameStart, e.fs);
        end
    end

    task automatic wait_fs(input string name, output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!FrameStart && n < 200);
        if (!FrameStart) begin
            checks++;
            errors++;
            $display("FAIL %s: no FrameStart within %0d cycles", name, n);
        end
    endtask

    int         obs_cnt   [4];
    logic [7:0] obs_seg   [4];
    int         obs_first [4];

    // Called in a FrameStart cycle; watches the 40 output cycles of that frame.
    task automatic observe_frame();
        for (int k = 0; k < N; k++) begin
            obs_cnt[k]   = 0;
            obs_seg[k]   = 8'hFF;
            obs_first[k] = -1;
        end
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge Clk);
            for (int k = 0; k < N; k++) begin
                if (SegmentDrivers == ~(4'b0001 << k)) begin
                    obs_cnt[k]++;
                    obs_seg[k] = SevenSegment;
                    if (obs_first[k] < 0) obs_first[k] = n;
                end
            end
        end
    endtask

    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic [1:0]      duty;
        logic            bl;
        logic [3:0][3:0] cnt;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t vecs [NV];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int lit_seen;
        logic [7:0] seg3, seg2;

        vecs[0] = '{bcd:16'h1234, dp:4'h0, duty:2'd3, bl:1'b0,
                    cnt:{4'd8, 4'd8, 4'd8, 4'd8}, seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{bcd:16'h1234, dp:4'h0, duty:2'd1, bl:1'b0,
                    cnt:{4'd2, 4'd2, 4'd2, 4'd2}, seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[2] = '{bcd:16'h1234, dp:4'h0, duty:2'd0, bl:1'b0,
                    cnt:{4'd0, 4'd0, 4'd0, 4'd0}, seg:{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{bcd:16'h0050, dp:4'b1000, duty:2'd3, bl:1'b1,
                    cnt:{4'd8, 4'd0, 4'd8, 4'd8}, seg:{8'h7F, 8'hFF, 8'h92, 8'hC0}};
        vecs[4] = '{bcd:16'h0000, dp:4'h0, duty:2'd2, bl:1'b1,
                    cnt:{4'd0, 4'd0, 4'd0, 4'd4}, seg:{8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[5] = '{bcd:16'hABCD, dp:4'b0101, duty:2'd3, bl:1'b1,
                    cnt:{4'd8, 4'd8, 4'd8, 4'd8}, seg:{8'h88, 8'h03, 8'hC6, 8'h21}};
        vecs[6] = '{bcd:16'h0E0F, dp:4'h0, duty:2'd3, bl:1'b1,
                    cnt:{4'd0, 4'd8, 4'd8, 4'd8}, seg:{8'hFF, 8'h86, 8'hC0, 8'h8E}};
        vecs[7] = '{bcd:16'h0050, dp:4'b1000, duty:2'd3, bl:1'b0,
                    cnt:{4'd8, 4'd8, 4'd8, 4'd8}, seg:{8'h40, 8'hC0, 8'h92, 8'hC0}};

        repeat (3) @(negedge Clk);
        check("rst_drivers", SegmentDrivers, 4'hF);
        check("rst_segments", SevenSegment, 8'hFF);
        check("rst_framestart", FrameStart, 1'b0);

        Reset  = 1'b0;
        Enable = 1'b1;
        Bcd    = 16'h1234;
        Duty   = 2'b11;
        wait_fs("rst_release", n);
        check("rst_release_to_frame", n, FRAME);

        for (int i = 0; i < NV; i++) begin
            Bcd          = vecs[i].bcd;
            Dp           = vecs[i].dp;
            Duty         = vecs[i].duty;
            BlankLeading = vecs[i].bl;
            wait_fs($sformatf("v%0d_fs", i), n);
            observe_frame();
            for (int k = 0; k < N; k++) begin
                check($sformatf("v%0d_lit_cycles_d%0d", i, k), obs_cnt[k], vecs[i].cnt[k]);
                check($sformatf("v%0d_segments_d%0d", i, k), obs_seg[k], vecs[i].seg[k]);
                if (vecs[i].cnt[k] != 0)
                    check($sformatf("v%0d_first_lit_d%0d", i, k), obs_first[k], BLANK + 1 + DIV * k);
            end
        end

        // Mid-frame Bcd change must not reach the display before the next frame.
        Bcd = 16'h1234; Dp = 4'h0; Duty = 2'b11; BlankLeading = 1'b0;
        wait_fs("tear_load", n);
        seg3 = 8'h00;
        seg2 = 8'h00;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge Clk);
            if (c == 15) Bcd = 16'h9876;
            if (SegmentDrivers == 4'b0111) seg3 = SevenSegment;
            if (SegmentDrivers == 4'b1011) seg2 = SevenSegment;
        end
        check("tear_old_d3", seg3, 8'hF9);
        check("tear_old_d2", seg2, 8'hA4);
        check("tear_fs_at_wrap", FrameStart, 1'b1);
        observe_frame();
        check("tear_new_d3", obs_seg[3], 8'h90);
        check("tear_new_d0", obs_seg[0], 8'h82);

        // Enable low for 15 cycles while the scan keeps running underneath.
        Bcd = 16'h1234;
        wait_fs("en_load", n);
        repeat (4) @(negedge Clk);
        check("en_pre_lit", SegmentDrivers, 4'b1110);
        Enable   = 1'b0;
        lit_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge Clk);
            if (c == 0) begin
                check("en_dark_drivers", SegmentDrivers, 4'hF);
                check("en_dark_segments", SevenSegment, 8'hFF);
            end
            if (SegmentDrivers != 4'hF) lit_seen++;
        end
        Enable = 1'b1;
        check("en_dark_cycles", lit_seen, 0);
        @(negedge Clk);
        check("en_resume_digit", SegmentDrivers, 4'b1101);
        wait_fs("en_period", n);
        check("en_frame_period", n, 20);

        // Asynchronous reset in the middle of a lit dwell.
        repeat (3) @(negedge Clk);
        check("mid_rst_pre_lit", SegmentDrivers, 4'b1110);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_drivers", SegmentDrivers, 4'hF);
        check("mid_rst_segments", SevenSegment, 8'hFF);
        check("mid_rst_framestart", FrameStart, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        wait_fs("mid_rst_release", n);
        check("mid_rst_to_frame", n, FRAME);
        observe_frame();
        check("mid_rst_restart_d0_cnt", obs_cnt[0], 8);
        check("mid_rst_restart_d0_seg", obs_seg[0], 8'h99);
        check("mid_rst_restart_d0_first", obs_first[0], BLANK + 1);

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
